mmio_device_arbiter: RTL and testbench

- Round-robin arbiter that shares one memory-mapped device port (for example the PE core monitor or another register block) between `NUM_HOSTS` MMIO host ports.
- Sits between the host-side interconnect and a single `mmio_if.device` endpoint.
- Grants one complete read or write transaction at a time and holds the grant until the device acknowledges.
- Steers the acknowledge and read data back to the winning host only.

---
 rtl/mmio_device_arbiter.sv | 123 ++++++++++++
 tb/tb_mmio_device_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_device_arbiter.sv
// mmio_device_arbiter: round-robin sharing of one MMIO device port among NUM_HOSTS hosts.
// Define MMIO_ARBITER_TIMEOUT_EN to add a BUSY watchdog that self-acks and sets timeout_error.
`ifndef TIA_WORD_WIDTH
`define TIA_WORD_WIDTH 32
`endif
module mmio_device_arbiter #(
  parameter int NUM_HOSTS = 2,
  parameter int INDEX_WIDTH = 16,
  parameter int DATA_WIDTH = `TIA_WORD_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_HOSTS-1:0]             host_read_req,
  input  logic [NUM_HOSTS*INDEX_WIDTH-1:0] host_read_index,
  output logic [NUM_HOSTS-1:0]             host_read_ack,
  output logic [NUM_HOSTS*DATA_WIDTH-1:0]  host_read_data,
  input  logic [NUM_HOSTS-1:0]             host_write_req,
  input  logic [NUM_HOSTS*INDEX_WIDTH-1:0] host_write_index,
  input  logic [NUM_HOSTS*DATA_WIDTH-1:0]  host_write_data,
  output logic [NUM_HOSTS-1:0]             host_write_ack,
  output logic                             device_read_req,
  output logic                             device_write_req,
  output logic [INDEX_WIDTH-1:0]           device_read_index,
  output logic [INDEX_WIDTH-1:0]           device_write_index,
  output logic [DATA_WIDTH-1:0]            device_write_data,
  input  logic                             device_read_ack,
  input  logic                             device_write_ack,
  input  logic [DATA_WIDTH-1:0]            device_read_data,
  output logic                             grant_valid,
  output logic [$clog2(NUM_HOSTS)-1:0]     grant_host,
  output logic                             timeout_error
);
  localparam int HW = $clog2(NUM_HOSTS);
  if (NUM_HOSTS < 2 || NUM_HOSTS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mmio_device_arbiter: NUM_HOSTS must be 2..8 and TIMEOUT_CYCLES >= 1");
  end
  typedef enum logic [1:0] {IDLE, READ_BUSY, WRITE_BUSY} state_t;
  state_t state, state_next;
  logic [HW-1:0] last_grant, winner;
  logic [NUM_HOSTS-1:0] wants;
  logic found, read_ack_ok, write_ack_ok, expire, finish;
  assign wants = host_read_req | host_write_req;
  assign read_ack_ok = state == READ_BUSY && device_read_ack;
  assign write_ack_ok = state == WRITE_BUSY && device_write_ack;
  assign finish = read_ack_ok || write_ack_ok || expire;
  // Second pass overrides the first, so hosts above last_grant take precedence over wrapped ones.
  always_comb begin
    winner = '0;
    found = 1'b0;
    for (int h = NUM_HOSTS - 1; h >= 0; h--)
      if (wants[h] && h <= int'(last_grant)) begin
        winner = HW'(h);
        found = 1'b1;
      end
    for (int h = NUM_HOSTS - 1; h >= 0; h--)
      if (wants[h] && h > int'(last_grant)) begin
        winner = HW'(h);
        found = 1'b1;
      end
  end
`ifdef MMIO_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] busy_cycles;
  logic timeout_flag;
  assign expire = state != IDLE && busy_cycles == CW'(TIMEOUT_CYCLES) && !read_ack_ok && !write_ack_ok;
  assign timeout_error = !reset && (timeout_flag || expire);
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_cycles <= '0;
      timeout_flag <= 1'b0;
    end else begin
      busy_cycles <= state == IDLE ? '0 : busy_cycles + CW'(1);
      timeout_flag <= timeout_flag || expire;
    end
  end
`else
  assign expire = 1'b0;
  assign timeout_error = 1'b0;
`endif
  always_ff @(posedge clock) state <= reset ? IDLE : state_next;
  always_comb
    state_next = state == IDLE ? (found ? (host_read_req[winner] ? READ_BUSY : WRITE_BUSY) : IDLE)
               : finish ? IDLE : state;
  always_ff @(posedge clock) begin
    if (reset) begin
      device_read_req <= 1'b0;
      device_write_req <= 1'b0;
      device_read_index <= '0;
      device_write_index <= '0;
      device_write_data <= '0;
      grant_valid <= 1'b0;
      grant_host <= '0;
      last_grant <= HW'(NUM_HOSTS - 1);
    end else if (state == IDLE && found) begin
      device_read_req <= host_read_req[winner];
      device_write_req <= !host_read_req[winner];
      if (host_read_req[winner])
        device_read_index <= host_read_index[winner*INDEX_WIDTH +: INDEX_WIDTH];
      else begin
        device_write_index <= host_write_index[winner*INDEX_WIDTH +: INDEX_WIDTH];
        device_write_data <= host_write_data[winner*DATA_WIDTH +: DATA_WIDTH];
      end
      grant_valid <= 1'b1;
      grant_host <= winner;
      last_grant <= winner;
    end else if (finish) begin
      device_read_req <= 1'b0;
      device_write_req <= 1'b0;
      grant_valid <= 1'b0;
    end
  end
  always_comb begin
    host_read_ack = '0;
    host_write_ack = '0;
    host_read_data = '0;
    if (!reset && state == READ_BUSY && finish) begin
      host_read_ack[grant_host] = 1'b1;
      host_read_data[grant_host*DATA_WIDTH +: DATA_WIDTH] = read_ack_ok ? device_read_data : '1;
    end
    if (!reset && state == WRITE_BUSY && finish) host_write_ack[grant_host] = 1'b1;
  end
endmodule

// File: tb/tb_mmio_device_arbiter.sv
// tb_mmio_device_arbiter: directed scenarios plus randomized hosts/device checked against a transaction model.
module tb_mmio_device_arbiter;
  localparam int N = 3, IW = 16, DW = 32, TO = 4;
  logic clock = 0, reset = 1;
  logic [N-1:0] host_read_req = '0, host_write_req = '0, host_read_ack, host_write_ack;
  logic [N*IW-1:0] host_read_index = '0, host_write_index = '0;
  logic [N*DW-1:0] host_write_data = '0, host_read_data;
  logic device_read_req, device_write_req, device_read_ack = 0, device_write_ack = 0;
  logic [IW-1:0] device_read_index, device_write_index;
  logic [DW-1:0] device_write_data, device_read_data = '0;
  logic grant_valid, timeout_error;
  logic [1:0] grant_host;

  mmio_device_arbiter #(.NUM_HOSTS(N), .INDEX_WIDTH(IW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .host_read_req(host_read_req), .host_read_index(host_read_index),
    .host_read_ack(host_read_ack), .host_read_data(host_read_data),
    .host_write_req(host_write_req), .host_write_index(host_write_index),
    .host_write_data(host_write_data), .host_write_ack(host_write_ack),
    .device_read_req(device_read_req), .device_write_req(device_write_req),
    .device_read_index(device_read_index), .device_write_index(device_write_index),
    .device_write_data(device_write_data), .device_read_ack(device_read_ack),
    .device_write_ack(device_write_ack), .device_read_data(device_read_data),
    .grant_valid(grant_valid), .grant_host(grant_host), .timeout_error(timeout_error));

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  bit rand_on = 0, spurious = 0, repost = 0, dev_never = 0, p_reset = 0, p_clear = 0, use_fix = 0;
  int dev_lat = 0, cur_lat = 0, dev_cnt = 0, cyc = 0;
  logic [DW-1:0] fix_data = '0;
  bit p_rd[N], p_wr[N], rd_acked[N], wr_acked[N];
  logic [IW-1:0] p_ri[N], p_wi[N];
  logic [DW-1:0] p_wd[N];
  int ack_log[$], ack_cyc[$];
  bit m_busy = 0, m_rd = 0, m_err = 0;
  int m_host = 0, m_last = N - 1, m_cnt = 0;
  logic [IW-1:0] m_idx = '0;
  logic [DW-1:0] m_wd = '0;

  task automatic post_read(input int h, input logic [IW-1:0] idx);
    p_rd[h] = 1; p_ri[h] = idx;
  endtask
  task automatic post_write(input int h, input logic [IW-1:0] idx, input logic [DW-1:0] d);
    p_wr[h] = 1; p_wi[h] = idx; p_wd[h] = d;
  endtask
  task automatic set_lat(input int l);
    dev_lat = l; cur_lat = l < 0 ? int'($urandom_range(0, 3)) : l; dev_cnt = 0;
  endtask

  task automatic step();
    logic [N-1:0] e_ra, e_wa;
    logic [N*DW-1:0] e_rd;
    bit done, hit, dropped;
    int w;
    @(posedge clock); #1;
    cyc++;
    reset = p_reset;
    if (p_clear) begin
      host_read_req = '0; host_write_req = '0; p_clear = 0;
      for (int h = 0; h < N; h++) begin p_rd[h] = 0; p_wr[h] = 0; rd_acked[h] = 0; wr_acked[h] = 0; end
    end
    for (int h = 0; h < N; h++) begin
      if (p_rd[h]) begin host_read_req[h] = 1; host_read_index[h*IW +: IW] = p_ri[h]; p_rd[h] = 0; end
      if (p_wr[h]) begin
        host_write_req[h] = 1; host_write_index[h*IW +: IW] = p_wi[h]; host_write_data[h*DW +: DW] = p_wd[h]; p_wr[h] = 0;
      end
      dropped = rd_acked[h] || wr_acked[h];
      if (rd_acked[h]) begin host_read_req[h] = 0; if (repost) post_read(h, IW'($urandom)); end
      if (wr_acked[h]) host_write_req[h] = 0;
      rd_acked[h] = 0; wr_acked[h] = 0;
      if (rand_on && !dropped && !host_read_req[h] && !host_write_req[h] && $urandom_range(0, 2) == 0) begin
        w = $urandom_range(0, 2);
        host_read_req[h] = w != 1; host_write_req[h] = w != 0;
        host_read_index[h*IW +: IW] = IW'($urandom);
        host_write_index[h*IW +: IW] = IW'($urandom);
        host_write_data[h*DW +: DW] = $urandom;
      end
    end
    check("grant_valid", grant_valid, m_busy);
    check("device_read_req", device_read_req, m_busy && m_rd);
    check("device_write_req", device_write_req, m_busy && !m_rd);
    if (m_busy) begin
      check("grant_host", grant_host, m_host);
      if (m_rd) check("device_read_index", device_read_index, m_idx);
      else begin
        check("device_write_index", device_write_index, m_idx);
        check("device_write_data", device_write_data, m_wd);
      end
    end
    device_read_ack = 0; device_write_ack = 0;
    device_read_data = use_fix ? fix_data : $urandom;
    if (!reset && (device_read_req || device_write_req)) begin
      if (!dev_never && dev_cnt >= cur_lat) begin
        device_read_ack = device_read_req; device_write_ack = device_write_req;
        set_lat(dev_lat);
      end else begin
        dev_cnt++;
        if (spurious && $urandom_range(0, 3) == 0) begin
          device_read_ack = device_write_req; device_write_ack = device_read_req;
        end
      end
    end else if (spurious && $urandom_range(0, 3) == 0)
      {device_read_ack, device_write_ack} = 2'($urandom_range(1, 3));
    #1;
    e_ra = '0; e_wa = '0; e_rd = '0;
    done = !reset && m_busy && (m_rd ? device_read_ack : device_write_ack);
    hit = 0;
`ifdef MMIO_ARBITER_TIMEOUT_EN
    hit = !reset && m_busy && !done && m_cnt == TO;
    check("timeout_error", timeout_error, !reset && (m_err || hit));
`else
    check("timeout_error", timeout_error, 1'b0);
`endif
    if (done || hit) begin
      if (m_rd) begin e_ra[m_host] = 1; e_rd[m_host*DW +: DW] = hit ? '1 : device_read_data; end
      else e_wa[m_host] = 1;
    end
    check("host_read_ack", host_read_ack, e_ra);
    check("host_write_ack", host_write_ack, e_wa);
    check("host_read_data", host_read_data, e_rd);
    for (int h = 0; h < N; h++) begin
      rd_acked[h] = host_read_ack[h]; wr_acked[h] = host_write_ack[h];
      if (host_read_ack[h] || host_write_ack[h]) begin ack_log.push_back(h); ack_cyc.push_back(cyc); end
    end
    if (reset) begin
      m_busy = 0; m_last = N - 1; m_host = 0; m_err = 0; m_cnt = 0; set_lat(dev_lat);
    end else if (m_busy) begin
      if (done || hit) begin m_busy = 0; m_err = m_err || hit; end
      else m_cnt++;
    end else
      for (int k = 1; k <= N; k++) begin
        int h;
        h = (m_last + k) % N;
        if (host_read_req[h] || host_write_req[h]) begin
          m_busy = 1; m_rd = host_read_req[h]; m_host = h; m_last = h; m_cnt = 0;
          m_idx = m_rd ? host_read_index[h*IW +: IW] : host_write_index[h*IW +: IW];
          m_wd = host_write_data[h*DW +: DW];
          break;
        end
      end
  endtask

  task automatic restart();
    repost = 0; rand_on = 0; spurious = 0; dev_never = 0;
    p_reset = 1; p_clear = 1;
    step();
    p_reset = 0;
    ack_log.delete(); ack_cyc.delete(); cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 1000000 expected earlier finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_host", grant_host, 0);
    check("rst_dev_reqs", {device_read_req, device_write_req}, 0);
    check("rst_dev_regs", {device_read_index, device_write_index, device_write_data}, 0);
    check("rst_host_acks", {host_read_ack, host_write_ack}, 0);
    check("rst_host_data", host_read_data, 0);
    check("rst_timeout", timeout_error, 0);
    cyc = -1;
    set_lat(0); use_fix = 1; fix_data = 32'h5; post_read(0, 16'h0002);
    step();
    check("t1_c0_req", device_read_req, 0);
    step();
    check("t1_dev_req", device_read_req, 1);
    check("t1_index", device_read_index, 16'h0002);
    check("t1_ack", host_read_ack, 3'b001);
    check("t1_data", host_read_data[DW-1:0], 32'h5);
    step();
    check("t1_idle", grant_valid, 0);
    use_fix = 0;

    restart(); set_lat(0); post_read(0, 16'h11); post_read(1, 16'h22);
    repeat (7) step();
    check("t2_count", ack_log.size(), 2);
    check("t2_first", ack_log.size() > 0 ? ack_log[0] : -1, 0);
    check("t2_second", ack_log.size() > 1 ? ack_log[1] : -1, 1);
    check("t2_spacing", ack_log.size() > 1 ? ack_cyc[1] - ack_cyc[0] : -1, 2);

    restart(); set_lat(0); repost = 1;
    for (int h = 0; h < N; h++) post_read(h, IW'($urandom));
    repeat (14) step();
    for (int i = 0; i < 6; i++)
      check($sformatf("t3_order%0d", i), i < ack_log.size() ? ack_log[i] : -1, i % 3);

    restart(); set_lat(3); post_write(1, 16'h0010, 32'hABCD);
    step();
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("t4_req_c%0d", c), device_write_req, 1);
      check($sformatf("t4_data_c%0d", c), device_write_data, 32'hABCD);
      check($sformatf("t4_ack_c%0d", c), host_write_ack, c == 4 ? 3'b010 : 3'b000);
    end
    step();
    check("t4_done", device_write_req, 0);

`ifdef MMIO_ARBITER_TIMEOUT_EN
    restart(); dev_never = 1; post_read(0, 16'h0007);
    step();
    for (int c = 1; c <= 5; c++) begin
      step();
      check($sformatf("t5_ack_c%0d", c), host_read_ack, c == 5 ? 3'b001 : 3'b000);
      check($sformatf("t5_err_c%0d", c), timeout_error, c == 5);
    end
    check("t5_data", host_read_data[DW-1:0], 32'hFFFF_FFFF);
    repeat (2) step();
    check("t5_sticky", timeout_error, 1);
    check("t5_req_low", device_read_req, 0);
    dev_never = 0;
`endif

    restart(); set_lat(5); post_read(0, 16'h0003);
    repeat (2) step();
    p_reset = 1; step(); p_reset = 0;
    check("t6_rst_ack", host_read_ack, 0);
    step();
    check("t6_req_low", device_read_req, 0);
    step();
    check("t6_regrant_req", device_read_req, 1);
    check("t6_regrant_host", grant_host, 0);
    check("t6_no_ack", ack_log.size(), 0);

    restart(); set_lat(-1); rand_on = 1; spurious = 1;
    for (int i = 0; i < 3000; i++) begin
      p_reset = $urandom_range(0, 299) == 0;
      step();
    end
    p_reset = 0;
    check("rand_progress", ack_log.size() > 200, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
